// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an iterative radix-2 multiply / restoring divide engine.
// Result lands WIDTH+1 cycles after Start is accepted; Busy stalls the pipeline meanwhile.
module hilo_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Start,
   input  logic [2:0]         Op,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [WIDTH-1:0]   HIin,
   input  logic [WIDTH-1:0]   LOin,
   input  logic               HWrite,
   input  logic               LWrite,
   output logic [WIDTH-1:0]   HI,
   output logic [WIDTH-1:0]   LO,
   output logic [2*WIDTH-1:0] HLout,
   output logic               Busy,
   output logic               Done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t              r_state;
   state_t              w_state_nx;
   logic [1:0]          r_op;
   logic                r_qsign;
   logic                r_rsign;
   logic                r_bzero;
   logic [CW-1:0]       r_cnt;
   logic                r_done;
   logic [WIDTH-1:0]    r_hi;
   logic [WIDTH-1:0]    r_lo;
   logic [WIDTH-1:0]    r_b;
   logic [2*WIDTH-1:0]  r_mcand;
   logic [2*WIDTH-1:0]  r_p;
   logic [WIDTH-1:0]    r_rem;
   logic [WIDTH-1:0]    r_quo;

   logic                w_sa;
   logic                w_sb;
   logic [WIDTH-1:0]    w_amag;
   logic [WIDTH-1:0]    w_bmag;
   logic                w_cnt_last;
   logic [WIDTH:0]      w_div_sh;
   logic [WIDTH:0]      w_div_diff;
   logic [2*WIDTH-1:0]  w_hl;
   logic [2*WIDTH-1:0]  w_prod_s;
   logic [2*WIDTH-1:0]  w_mac;
   logic [WIDTH-1:0]    w_quo_s;
   logic [WIDTH-1:0]    w_rem_s;

   // Op[0]=1 selects the unsigned variant of every operation.
   assign w_sa   = ~Op[0] & A[WIDTH-1];
   assign w_sb   = ~Op[0] & B[WIDTH-1];
   assign w_amag = w_sa ? -A : A;
   assign w_bmag = w_sb ? -B : B;

   assign w_cnt_last = (r_cnt == CW'(WIDTH - 1));
   assign w_div_sh   = {r_rem, r_quo[WIDTH-1]};
   assign w_div_diff = w_div_sh - {1'b0, r_b};

   assign w_hl     = {r_hi, r_lo};
   assign w_prod_s = r_qsign ? -r_p : r_p;
   assign w_mac    = r_op[0] ? (w_hl - w_prod_s) : (w_hl + w_prod_s);
   // A zero divisor yields an all-ones quotient regardless of the dividend sign.
   assign w_quo_s  = r_bzero ? {WIDTH{1'b1}} : (r_qsign ? -r_quo : r_quo);
   assign w_rem_s  = r_rsign ? -r_rem : r_rem;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      Busy       = 1'b1;
      case (r_state)
         S_IDLE: begin
            Busy = 1'b0;
            if (Start) w_state_nx = (Op[2:1] == 2'b01) ? S_DIV : S_MUL;
         end
         S_MUL, S_DIV: if (w_cnt_last) w_state_nx = S_FIX;
         S_FIX:   w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_op    <= '0;
         r_qsign <= 1'b0;
         r_rsign <= 1'b0;
         r_bzero <= 1'b0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_b     <= '0;
         r_mcand <= '0;
         r_p     <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
      end else begin
         r_done <= (r_state == S_FIX);
         case (r_state)
            S_IDLE: begin
               if (HWrite) r_hi <= HIin;
               if (LWrite) r_lo <= LOin;
               if (Start) begin
                  r_op    <= Op[2:1];
                  r_qsign <= w_sa ^ w_sb;
                  r_rsign <= w_sa;
                  r_bzero <= (B == '0);
                  r_cnt   <= '0;
                  r_b     <= w_bmag;
                  r_mcand <= {{WIDTH{1'b0}}, w_amag};
                  r_p     <= '0;
                  r_rem   <= '0;
                  r_quo   <= w_amag;
               end
            end
            S_MUL: begin
               if (r_b[0]) r_p <= r_p + r_mcand;
               r_mcand <= r_mcand << 1;
               r_b     <= r_b >> 1;
               r_cnt   <= r_cnt + CW'(1);
            end
            S_DIV: begin
               // Restoring step: keep the shifted remainder when the trial subtract underflows.
               if (!w_div_diff[WIDTH]) begin
                  r_rem <= w_div_diff[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b1};
               end else begin
                  r_rem <= w_div_sh[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b0};
               end
               r_cnt <= r_cnt + CW'(1);
            end
            S_FIX: begin
               if (r_op == 2'b01)  {r_hi, r_lo} <= {w_rem_s, w_quo_s};
               else if (!r_op[1])  {r_hi, r_lo} <= w_prod_s;
               else                {r_hi, r_lo} <= w_mac;
            end
            default: ;
         endcase
      end
   end

   assign HI    = r_hi;
   assign LO    = r_lo;
   assign HLout = {r_hi, r_lo};
   assign Done  = r_done;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: issued ops push expected {HI,LO} and Done cycle,
// a negedge monitor pops and compares on every Done pulse.
module tb_hilo_muldiv_unit;

   localparam int W = 32;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          Start;
   logic [2:0]    Op;
   logic [W-1:0]  A, B, HIin, LOin;
   logic          HWrite, LWrite;
   logic [W-1:0]  HI, LO;
   logic [2*W-1:0] HLout;
   logic          Busy, Done;

   hilo_muldiv_unit #(.WIDTH(W)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
      .HIin(HIin), .LOin(LOin), .HWrite(HWrite), .LWrite(LWrite),
      .HI(HI), .LO(LO), .HLout(HLout), .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [63:0] hl;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   always @(posedge Clk) cyc <= cyc + 1;

   // Reference: plain 64-bit arithmetic straight from the instruction definitions.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hl);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] ua, ub, p;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'b0, a};
      ub = {32'b0, b};
      p  = op[0] ? ua * ub : sa * sb;
      case (op)
         3'b010, 3'b011: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (op[0]) return {32'(ua % ub), 32'(ua / ub)};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'b100, 3'b101: return hl + p;
         3'b110, 3'b111: return hl - p;
         default:        return p;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   always @(negedge Clk) begin
      if (Done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: Done=1 at cycle %0d with nothing outstanding", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("result_hlout", HLout, e.hl);
            check("result_hi_lo", {HI, LO}, e.hl);
            check("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic mt(input logic hw, input logic [31:0] hin, input logic lw, input logic [31:0] lin);
      @(negedge Clk);
      HWrite = hw; HIin = hin; LWrite = lw; LOin = lin;
      if (hw) m_hi = hin;
      if (lw) m_lo = lin;
      @(negedge Clk);
      HWrite = 1'b0; LWrite = 1'b0;
      check("mt_hilo", {HI, LO}, {m_hi, m_lo});
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic hw, input logic [31:0] hin, input logic poke);
      exp_t e;
      int   n;
      @(negedge Clk);
      Op = op; A = a; B = b; Start = 1'b1; HWrite = hw; HIin = hin;
      if (hw) m_hi = hin;
      e.hl  = model(op, a, b, {m_hi, m_lo});
      e.cyc = cyc + W + 2;
      {m_hi, m_lo} = e.hl;
      sb_q.push_back(e);
      @(negedge Clk);
      n = 0;
      while (Busy === 1'b1 && n < 200) begin
         if (poke && n == 5) begin
            Start = 1'b1; HWrite = 1'b1; LWrite = 1'b1;
            HIin = $urandom; LOin = $urandom; A = $urandom; Op = 3'($urandom);
         end else begin
            Start = 1'b0; HWrite = 1'b0; LWrite = 1'b0;
         end
         @(negedge Clk);
         n++;
      end
      Start = 1'b0; HWrite = 1'b0; LWrite = 1'b0;
      check("busy_cycles", 64'(n), 64'(W + 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
      HIin = '0; LOin = '0; HWrite = 1'b0; LWrite = 1'b0;
      repeat (2) @(negedge Clk);
      check("reset_hilo", HLout, 64'h0);
      check("reset_busy", 64'(Busy), 64'h0);
      check("reset_done", 64'(Done), 64'h0);
      Rst = 1'b0;

      // Reset mid-divide: everything clears at once and the aborted op never signals Done.
      mt(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678);
      @(negedge Clk);
      Op = 3'b010; A = 32'd100; B = 32'd7; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (9) @(negedge Clk);
      Rst = 1'b1;
      #1;
      check("midrst_busy", 64'(Busy), 64'h0);
      check("midrst_hilo", HLout, 64'h0);
      m_hi = '0; m_lo = '0;
      @(negedge Clk);
      Rst = 1'b0;
      run_op(3'b001, 32'd6, 32'd9, 1'b0, '0, 1'b0);

      run_op(3'b000, 32'hFFFF_FFFD, 32'd7, 1'b0, '0, 1'b0);
      check("mult_neg3x7", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0, 1'b0);
      run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0, '0, 1'b0);
      run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0, 1'b0);
      run_op(3'b011, 32'd5, 32'd0, 1'b0, '0, 1'b0);
      run_op(3'b010, 32'hFFFF_FFF9, 32'd0, 1'b0, '0, 1'b0);

      mt(1'b1, 32'h0, 1'b1, 32'h0000_000A);
      run_op(3'b100, 32'd2, 32'd3, 1'b0, '0, 1'b0);
      run_op(3'b111, 32'd1, 32'h11, 1'b0, '0, 1'b0);

      // Writes and Starts during Busy must vanish; HWrite in the accepting cycle must stick.
      run_op(3'b000, 32'h0001_2345, 32'hFFFF_0F0F, 1'b0, '0, 1'b1);
      run_op(3'b101, 32'h0, 32'h0, 1'b1, 32'h1, 1'b0);
      check("maddu_hi_after_mthi", 64'(HI), 64'h1);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) mt(1'($urandom), $urandom, 1'($urandom), $urandom);
         run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 4) == 0),
                $urandom, 1'($urandom_range(0, 5) == 0));
      end

      repeat (4) @(negedge Clk);
      check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
